serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial two's-complement subtractor: diff = a - b, LSB first.
//   Built from one full-adder cell plus a registered borrow.
//   Sits beside the full-adder datapath as its inverse operation.
//   Trades WIDTH cycles of latency for a single 1-bit arithmetic cell.
// PARAMETERS
//   WIDTH  8  operand and result width in bits; legal range 2..32
// PORTS
//   clk     in   1      rising-edge clock; the only clock
//   rst     in   1      asynchronous, active-high reset
//   start   in   1      request a subtraction; sampled on rising clk
//   a       in   WIDTH  minuend; sampled only when start is accepted
//   b       in   WIDTH  subtrahend; sampled only when start is accepted
//   busy    out  1      high while a subtraction is in progress
//   done    out  1      one-cycle pulse: diff/borrow now valid
//   diff    out  WIDTH  (a - b) mod 2^WIDTH; held until next accept
//   borrow  out  1      1 when a < b (unsigned); held like diff
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - State -> IDLE; busy=0, done=0, diff=0, borrow=0.
//   - Shift regs, bit counter and internal borrow flop all cleared.
//   States: IDLE, SHIFT, DONE.
//   Accept:
//   - start=1 at an edge while in IDLE or DONE accepts a request.
//   - Latch a->sa and b->sb, clear the borrow flop, load count=0, go to SHIFT.
//   - start while in SHIFT is ignored; there is no queueing and no error flag.
//   SHIFT (one bit per edge):
//   - d_i  = sa[0] ^ ~sb[0] ^ ~bf   (full adder: a + ~b + carry-in, where ci = ~bf)
//   - bf' = ~carry_out
//   - Shift sa and sb right by 1; shift d_i into diff from the MSB side.
//   - count += 1.
//   - After the WIDTH-th SHIFT edge, move to DONE.
//   - The counter is $clog2(WIDTH+1) bits wide and never wraps in use.
//   DONE (exactly one cycle):
//   - done=1, busy=0; borrow = final bf.
//   - Next state is IDLE, or SHIFT if start=1 at this edge.
//   - Back-to-back requests therefore run with no gap.
//   Latency and outputs:
//   - Accept at edge N -> done high in the cycle after edge N+WIDTH.
//   - busy=1 exactly in the cycles after edges N .. N+WIDTH-1.
//   - diff changes only during SHIFT; read it only when done=1 or in IDLE.
//   - borrow updates only on the SHIFT->DONE transition.
//   Boundary cases:
//   - a == b gives diff=0, borrow=0.
//   - a=0, b=2^W-1 gives diff=1, borrow=1.
//   - a, b and start are don't-care outside the accept edge.
//   - rst asserted mid-SHIFT aborts immediately: all outputs go to 0.
//     No done pulse is generated for the aborted operation.
// TESTING (WIDTH=8, start is a one-cycle pulse unless stated)
//   1. a=5, b=3 -> done 8 edges after accept; diff=0x02, borrow=0.
//   2. a=3, b=5 -> diff=0xFE, borrow=1; busy high for exactly 8 cycles.
//   3. a=0x00, b=0x01 -> 0xFF/1.  a=0xA5, b=0xA5 -> 0x00/0.
//      a=0x00, b=0xFF -> 0x01/1.
//   4. start re-pulsed with a=9, b=9 while busy -> ignored; original result returned.
//   5. start held high with new operands (7, 2) during DONE -> second op accepted.
//      busy rises next cycle; second done gives diff=0x05, borrow=0.
//   6. rst pulsed 3 edges into SHIFT -> outputs 0 at once, no done.
//      Fresh start afterwards with a=0x10, b=0x01 -> diff=0x0F, borrow=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first: diff = a - b.
// One full-adder cell computes a + ~b + ~borrow per cycle; the borrow is kept in a flop.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             bf;
    logic [CW-1:0]    count;

    // Single full-adder cell: a + ~b + carry-in, where carry-in is the inverted borrow.
    logic fa_a;
    logic fa_b;
    logic fa_ci;
    logic fa_sum;
    logic fa_co;

    assign fa_a   = sa[0];
    assign fa_b   = ~sb[0];
    assign fa_ci  = ~bf;
    assign fa_sum = fa_a ^ fa_b ^ fa_ci;
    assign fa_co  = (fa_a & fa_b) | (fa_ci & (fa_a ^ fa_b));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            bf     <= 1'b0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        bf    <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end

                SHIFT: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    diff  <= {fa_sum, diff[WIDTH-1:1]};
                    bf    <= ~fa_co;
                    count <= count + CW'(1);
                    // Last bit: publish the final borrow and pulse done.
                    if (count == CW'(WIDTH - 1)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        borrow <= ~fa_co;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8): vector table plus
// hand-written sequences for ignored restart, back-to-back requests and mid-run reset.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int checks;
    int passed;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_diff;
        logic             exp_borrow;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Pulse start for one edge; returns at the first falling edge after the accept edge.
    task automatic apply(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count falling edges (including the current one) until done is seen; -1 on timeout.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) return;
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        cycles = -1;
    endtask

    initial begin
        int cyc;
        int bcnt;
        int done_seen;
        logic [WIDTH-1:0] held;

        checks = 0;
        passed = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        vecs[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
        vecs[7] = '{8'hFF, 8'h00, 8'hFF, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy",   int'(busy),   0);
        check("reset done",   int'(done),   0);
        check("reset diff",   int'(diff),   0);
        check("reset borrow", int'(borrow), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", int'(busy), 0);

        // Table-driven vectors: result, latency, busy width, one-cycle done, held diff
        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].a, vecs[i].b);
            wait_done(cyc, bcnt);
            check($sformatf("vec%0d latency", i), cyc, 9);
            check($sformatf("vec%0d busy cycles", i), bcnt, 8);
            check($sformatf("vec%0d diff", i), int'(diff), int'(vecs[i].exp_diff));
            check($sformatf("vec%0d borrow", i), int'(borrow), int'(vecs[i].exp_borrow));
            @(negedge clk);
            check($sformatf("vec%0d done pulse", i), int'(done), 0);
            check($sformatf("vec%0d diff held", i), int'(diff), int'(vecs[i].exp_diff));
        end

        // Restart while busy is ignored
        apply(8'h40, 8'h11);
        repeat (3) @(negedge clk);
        a     = 8'h09;
        b     = 8'h09;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcnt);
        check("ignore restart timing", cyc, 5);
        check("ignore restart diff",   int'(diff),   8'h2F);
        check("ignore restart borrow", int'(borrow), 0);
        @(negedge clk);
        check("ignore restart no 2nd op", int'(busy), 0);

        // Back-to-back: start held during DONE
        apply(8'h30, 8'h10);
        wait_done(cyc, bcnt);
        check("b2b first diff", int'(diff), 8'h20);
        a     = 8'h07;
        b     = 8'h02;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy rises", int'(busy), 1);
        check("b2b done low",   int'(done), 0);
        wait_done(cyc, bcnt);
        check("b2b second latency", cyc, 9);
        check("b2b second diff",    int'(diff),   8'h05);
        check("b2b second borrow",  int'(borrow), 0);

        // Reset mid-SHIFT aborts; previous borrow=1 result set first so zeroing is visible
        apply(8'h03, 8'h05);
        wait_done(cyc, bcnt);
        apply(8'h55, 8'h22);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy",   int'(busy),   0);
        check("abort done",   int'(done),   0);
        check("abort diff",   int'(diff),   0);
        check("abort borrow", int'(borrow), 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("abort no done", done_seen, 0);
        apply(8'h10, 8'h01);
        wait_done(cyc, bcnt);
        check("post abort latency", cyc, 9);
        check("post abort diff",    int'(diff),   8'h0F);
        check("post abort borrow",  int'(borrow), 0);
        held = diff;
        repeat (3) @(negedge clk);
        check("idle diff held", int'(diff), int'(held));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
